// File: rtl/ct_f_spsram_access_ctrl_if.sv
// Bundle of the host request/response, fill control and SRAM pins used by the
// single-port SRAM access controller.
interface ct_f_spsram_access_ctrl_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 84
);
    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] req_wmask;
    logic                  rsp_vld;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  init_start;
    logic                  init_busy;
    logic                  init_done;
    logic [ADDR_WIDTH-1:0] A;
    logic                  CEN;
    logic                  GWEN;
    logic [DATA_WIDTH-1:0] WEN;
    logic [DATA_WIDTH-1:0] D;
    logic [DATA_WIDTH-1:0] Q;

    // Environment side: host plus the SRAM macro returning Q.
    modport master (
        output req_vld, req_wr, req_addr, req_wdata, req_wmask, init_start, Q,
        input  req_rdy, rsp_vld, rsp_rdata, init_busy, init_done, A, CEN, GWEN, WEN, D
    );

    // Controller side.
    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, req_wmask, init_start, Q,
        output req_rdy, rsp_vld, rsp_rdata, init_busy, init_done, A, CEN, GWEN, WEN, D
    );
endinterface

// File: rtl/ct_f_spsram_access_ctrl.sv
// Drives the active-low port of a single-port SRAM from a valid/ready request
// stream, returns read data after two cycles, and fills the array on demand.
module ct_f_spsram_access_ctrl #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 84,
    parameter int                    DEPTH      = 4096,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input logic                    CLK,
    input logic                    RST,
    ct_f_spsram_access_ctrl_if.slave bus
);
    // One extra counter bit lets DEPTH == 2**ADDR_WIDTH finish without wrapping.
    localparam int                    CNT_W    = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic {S_IDLE, S_INIT} state_t;

    state_t                state;
    logic [CNT_W-1:0]      fill_cnt;
    logic                  init_busy_r;
    logic                  init_done_r;
    logic                  accept;
    logic                  vld_p0;
    logic                  vld_p1;
    logic                  vld_p2;
    logic [DATA_WIDTH-1:0] rdata_p2;
    logic [ADDR_WIDTH-1:0] a_hold;
    logic [DATA_WIDTH-1:0] d_hold;
    logic                  cen_c;
    logic                  gwen_c;
    logic [DATA_WIDTH-1:0] wen_c;
    logic [ADDR_WIDTH-1:0] a_c;
    logic [DATA_WIDTH-1:0] d_c;

    assign bus.req_rdy = (state == S_IDLE) & ~bus.init_start & ~RST;
    assign accept      = bus.req_vld & bus.req_rdy;
    assign vld_p0      = accept & ~bus.req_wr;

    // Pins follow the accepted request in the same cycle; when idle, A and D
    // keep the last driven values so the macro inputs do not toggle.
    always_comb begin
        cen_c  = 1'b1;
        gwen_c = 1'b1;
        wen_c  = ALL_ONES;
        a_c    = a_hold;
        d_c    = d_hold;
        if (state == S_INIT) begin
            cen_c  = 1'b0;
            gwen_c = 1'b0;
            wen_c  = '0;
            a_c    = fill_cnt[ADDR_WIDTH-1:0];
            d_c    = INIT_VALUE;
        end else if (accept) begin
            cen_c  = 1'b0;
            gwen_c = ~bus.req_wr;
            wen_c  = bus.req_wr ? ~bus.req_wmask : ALL_ONES;
            a_c    = bus.req_addr;
            d_c    = bus.req_wdata;
        end
    end

    assign bus.CEN  = cen_c;
    assign bus.GWEN = gwen_c;
    assign bus.WEN  = wen_c;
    assign bus.A    = a_c;
    assign bus.D    = d_c;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            fill_cnt    <= '0;
            init_busy_r <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            init_done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.init_start) begin
                        state       <= S_INIT;
                        fill_cnt    <= '0;
                        init_busy_r <= 1'b1;
                    end
                end
                S_INIT: begin
                    if (fill_cnt == LAST_IDX) begin
                        state       <= S_IDLE;
                        fill_cnt    <= '0;
                        init_busy_r <= 1'b0;
                        init_done_r <= 1'b1;
                    end else begin
                        fill_cnt <= fill_cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_hold   <= '0;
            d_hold   <= '0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            rdata_p2 <= '0;
        end else begin
            a_hold <= a_c;
            d_hold <= d_c;
            // p0 -> p1: read issued to the macro, Q arrives this next cycle
            vld_p1 <= vld_p0;
            // p1 -> p2: capture Q into the response register
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                rdata_p2 <= bus.Q;
            end
        end
    end

    assign bus.rsp_vld   = vld_p2;
    assign bus.rsp_rdata = rdata_p2;
    assign bus.init_busy = init_busy_r;
    assign bus.init_done = init_done_r;
endmodule

// File: doc/ct_f_spsram_access_ctrl.md
Name: ct_f_spsram_access_ctrl

Overview:
- Initiator-side controller that owns and drives the active-low port of a single-port FPGA SRAM macro: A, CEN, GWEN, per-bit WEN, D, with Q returned.
- Converts a valid/ready host request stream (read, or bit-masked write) into SRAM cycles and returns read data on a response strobe.
- Provides a hardware initialise sequence that fills every entry with a constant.
- Sits between cache/buffer logic and the 4096x84 array wrapper.

Parameters:
- ADDR_WIDTH, 12, SRAM address width.
- DATA_WIDTH, 84, SRAM data width.
- DEPTH, 4096, number of entries initialised; must be ≤ 2^ADDR_WIDTH.
- INIT_VALUE, 84'h0, word written to every entry during init.

Ports:
- CLK  input  1  single clock for all logic and the SRAM.
- RST  input  1  asynchronous, active-high reset.
- req_vld  input  1  host request valid.
- req_rdy  output  1  controller can accept a request this cycle.
- req_wr  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  request address.
- req_wdata  input  DATA_WIDTH  write data.
- req_wmask  input  DATA_WIDTH  1 = write this bit (active-high, host side).
- rsp_vld  output  1  read data valid, one-cycle pulse.
- rsp_rdata  output  DATA_WIDTH  read data; holds its value until the next response.
- init_start  input  1  pulse to begin the fill sequence.
- init_busy  output  1  fill in progress.
- init_done  output  1  one-cycle pulse after the last fill write.
- A  output  ADDR_WIDTH  SRAM address.
- CEN  output  1  SRAM chip enable, active-low.
- GWEN  output  1  SRAM global write enable, active-low.
- WEN  output  DATA_WIDTH  SRAM per-bit write enable, active-low.
- D  output  DATA_WIDTH  SRAM write data.
- Q  input  DATA_WIDTH  SRAM read data, valid the cycle after the read access.

Behaviour:
- Reset is asynchronous, active-high. While RST is high and after release:
  - State is IDLE.
  - CEN=1, GWEN=1, WEN=all ones, A=0, D=0.
  - req_rdy=0 while RST is high.
  - rsp_vld=0, rsp_rdata=0, init_busy=0, init_done=0.
  - Fill counter = 0 and the read pipeline is flushed.
- States:
  - IDLE → INIT on init_start.
  - INIT → IDLE after the write to DEPTH-1.
- req_rdy = (state==IDLE) & !init_start & !RST.
- Accept occurs when req_vld & req_rdy. In the same cycle the SRAM pins are driven combinationally:
  - CEN=0, A=req_addr.
  - GWEN = !req_wr.
  - WEN = req_wr ? ~req_wmask : all ones.
  - D = req_wdata.
- When there is no accept and state is IDLE, the SRAM pins are idle: CEN=1, GWEN=1, WEN=all ones. A and D are don't-care; hold them at their last values.
- A write with req_wmask=0 still asserts CEN and GWEN but changes no bits.
- Read pipeline:
  - Read accepted in cycle N; Q is valid in N+1 and is registered into rsp_rdata at the end of N+1.
  - rsp_vld is high in N+2. Fixed latency is 2.
  - One read per cycle is sustained; back-to-back reads give back-to-back rsp_vld pulses in order.
  - There is no response backpressure.
- INIT:
  - init_busy=1 and req_rdy=0.
  - Each cycle drives CEN=0, GWEN=0, WEN=all zeros, D=INIT_VALUE, A=counter, then increments the counter.
  - The fill takes exactly DEPTH cycles, starting the cycle after init_start is sampled.
  - init_done pulses in the cycle after the write to DEPTH-1; init_busy falls in that same cycle and the counter returns to 0.
- init_start rules:
  - init_start while reads are in flight: those responses still complete at their scheduled cycles.
  - init_start asserted during INIT is ignored.
  - init_start together with req_vld: init wins; the request is not accepted and must be held by the host.
- Reset mid-INIT aborts the fill immediately and returns to IDLE; init_done does not pulse. Entries already written keep INIT_VALUE; the rest are unchanged.
- Counter width is ADDR_WIDTH+1 so that DEPTH = 2^ADDR_WIDTH terminates without wrap-around.

Test Plan:
- Reset release, idle 10 cycles → CEN=1, GWEN=1, WEN=all ones, rsp_vld=0, req_rdy=1.
- Write addr 0x005, data all ones, mask all ones; then read 0x005 → in the read-accept cycle CEN=0, GWEN=1; rsp_vld exactly 2 cycles later with rsp_rdata = all ones.
- Write addr 0x005, data 0, mask = 84'h1 (bit 0 only); read → rsp_rdata = all ones except bit 0 = 0, showing per-bit WEN was low only on bit 0.
- Four back-to-back reads to 0x000–0x003 preloaded with 1, 2, 3, 4 → four consecutive rsp_vld pulses returning 1, 2, 3, 4 in order.
- init_start with INIT_VALUE=84'hA5 → init_busy high for 4096 cycles, req_rdy=0 throughout, init_done pulses once. Reads of 0x000, 0x7FF and 0xFFF each return 84'hA5.
- RST asserted 100 cycles into INIT → outputs return to reset values asynchronously and no init_done pulse occurs. After release, 0x000–0x062 read INIT_VALUE and 0x0FF keeps its prior contents.
